// File: rtl/left_rotate_seq.sv
`default_nettype none
// ============================================================================
//  Module      : left_rotate_seq
//  Description : Multi-cycle left rotate / shift-left-logical unit. The
//                latched operand moves one bit left per clock until the
//                requested count is consumed. The result is registered and
//                held until the next completion. Handshake is start/busy/done.
//  Revision    : 1.0  initial release
// ============================================================================
module left_rotate_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic             Op,
    output logic [WIDTH-1:0] Out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] out_q, out_d;

    // Working value advanced by one position; op_q selects wrap or zero fill
    logic [WIDTH-1:0] w_shifted;
    logic             w_accept;

    // One-step move of the working value and request acceptance
    always_comb begin
        w_shifted = {work_q[WIDTH-2:0], (op_q ? 1'b0 : work_q[WIDTH-1])};
        w_accept  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        op_d    = op_q;
        out_d   = out_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (Cnt == '0) begin
                        // Zero count completes immediately with the operand as result
                        out_d   = In;
                        state_d = S_DONE;
                    end else begin
                        work_d  = In;
                        rem_d   = Cnt;
                        op_d    = Op;
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                rem_d = rem_q - 1'b1;
                if (rem_q == CNT_W'(1)) begin
                    // Final step lands directly in the result register
                    out_d   = w_shifted;
                    state_d = S_DONE;
                end else begin
                    work_d = w_shifted;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            op_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            out_q   <= out_d;
        end
    end

    // Moore outputs
    always_comb begin
        Out  = out_q;
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_left_rotate_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_left_rotate_seq
//  Description : Self-checking bench for left_rotate_seq. A transaction-level
//                model predicts Out/busy/done every cycle; directed vectors
//                also carry hand-computed results and latencies.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_left_rotate_seq;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] In = '0;
    logic [CNT_W-1:0] Cnt = '0;
    logic             Op = 1'b0;
    logic [WIDTH-1:0] Out;
    logic             busy;
    logic             done;

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    left_rotate_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .In    (In),
        .Cnt   (Cnt),
        .Op    (Op),
        .Out   (Out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result computed from the operation definition
    function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] x,
                                                    input int n, input logic op);
        logic [2*WIDTH-1:0] dbl;
        logic [2*WIDTH-1:0] ext;
        dbl = {x, x} << n;
        ext = {{WIDTH{1'b0}}, x} << n;
        return op ? ext[WIDTH-1:0] : dbl[2*WIDTH-1:WIDTH];
    endfunction

    // Transaction model: remaining busy cycles, pending result, done flag
    int               m_left = 0;
    bit               m_done = 1'b0;
    logic [WIDTH-1:0] m_out = '0;
    logic [WIDTH-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_out  = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_out  = m_pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                if (Cnt == 0) begin
                    m_out  = In;
                    m_done = 1'b1;
                end else begin
                    m_left = int'(Cnt);
                    m_pend = ref_result(In, int'(Cnt), Op);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_out",  32'(Out),  32'(m_out));
            chk("cyc_busy", 32'(busy), 32'(m_left > 0));
            chk("cyc_done", 32'(done), 32'(m_done));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Issue a one-cycle start, then scramble the inputs
    task automatic go(input logic [WIDTH-1:0] a, input logic [CNT_W-1:0] c, input logic o);
        start = 1'b1;
        In    = a;
        Cnt   = c;
        Op    = o;
        tick(1);
        start = 1'b0;
        In    = 16'hA5C3;
        Cnt   = 4'd9;
        Op    = ~o;
    endtask

    // Wait (bounded) for done; check result, model agreement and latency
    task automatic wait_done(input string name, input logic [WIDTH-1:0] exp, input int exp_lat);
        int n;
        bit seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({name, "_out"},   32'(Out),   32'(exp));
            chk({name, "_model"}, 32'(m_out), 32'(exp));
            if (exp_lat >= 0) chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        end
    endtask

    initial begin
        // Reset and idle
        tick(2);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out",  32'(Out),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        tick(1);
        rst = 1'b0;
        tick(3);
        chk("idle_out", 32'(Out), 32'h0);

        // Basic rotate
        go(16'h1234, 4'd4, 1'b0);
        wait_done("rol_1234_4", 16'h2341, 5);
        tick(1);

        // Zero count
        go(16'hBEEF, 4'd0, 1'b0);
        chk("cnt0_busy", 32'(busy), 32'h0);
        wait_done("cnt0_beef", 16'hBEEF, 1);
        tick(1);

        // Wrap of the MSB
        go(16'h8001, 4'd1, 1'b0);
        wait_done("rol_8001_1", 16'h0003, 2);
        tick(1);

        // Maximum count
        go(16'h0001, 4'd15, 1'b0);
        wait_done("rol_0001_15", 16'h8000, 16);
        tick(1);

        // Shift left logical
        go(16'h1234, 4'd4, 1'b1);
        wait_done("sll_1234_4", 16'h2340, 5);
        tick(1);
        go(16'hFFFF, 4'd15, 1'b1);
        wait_done("sll_ffff_15", 16'h8000, 16);
        tick(1);

        // start during RUN is ignored
        go(16'h00FF, 4'd6, 1'b0);
        tick(1);
        start = 1'b1;
        In    = 16'hFFFF;
        Cnt   = 4'd1;
        Op    = 1'b1;
        tick(1);
        start = 1'b0;
        chk("run_ignore_busy", 32'(busy), 32'h1);
        wait_done("run_ignore", 16'h3FC0, -1);
        tick(1);

        // Back-to-back acceptance from DONE
        go(16'h1234, 4'd4, 1'b0);
        wait_done("b2b_first", 16'h2341, 5);
        start = 1'b1;
        In    = 16'h00F0;
        Cnt   = 4'd2;
        Op    = 1'b0;
        tick(1);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'h1);
        wait_done("b2b_second", 16'h03C0, 3);
        tick(1);

        // Reset mid-operation
        go(16'h1234, 4'd8, 1'b0);
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("abort_out",  32'(Out),  32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        tick(10);
        go(16'h8001, 4'd1, 1'b0);
        wait_done("after_abort", 16'h0003, 2);
        tick(3);
        chk("hold_out", 32'(Out), 32'h0003);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
